// File: rtl/gpio_pwm_ctrl_if.sv
// Command/response bus between the SPI command decoder and the pin controller.
interface gpio_pwm_ctrl_if;
  logic [7:0]  Cmd;
  logic [7:0]  Addr;
  logic [31:0] Data;
  logic        AddrStrobe;
  logic        DataStrobe;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;

  modport master (
    output Cmd, Addr, Data, AddrStrobe, DataStrobe,
    input  Rd_Data, Rd_Valid
  );

  modport slave (
    input  Cmd, Addr, Data, AddrStrobe, DataStrobe,
    output Rd_Data, Rd_Valid
  );
endinterface

// File: rtl/gpio_pwm_ctrl.sv
// GPIO/PWM pin controller: per-pin mode/output/edge-interrupt state,
// synchronised input sampling and a registered read-back path.
module gpio_pwm_ctrl #(
  parameter int   NUM_PORTS = 8,
  parameter int   PWM_PORTS = 4,
  localparam int  NPINS     = 8 * NUM_PORTS,
  localparam int  PWM_W     = (PWM_PORTS == 0) ? 1 : 8 * PWM_PORTS
) (
  input  logic               Clk,
  input  logic               Reset_n,
  gpio_pwm_ctrl_if.slave     bus,
  input  logic [PWM_W-1:0]   PWM,
  input  logic [NPINS-1:0]   Pin_In,
  output logic [NPINS-1:0]   Pin_Out,
  output logic [NPINS-1:0]   Pin_Oe,
  output logic               Irq
);

  localparam int NWORDS   = (NPINS + 31) / 32;
  localparam int PWM_PINS = 8 * PWM_PORTS;

  // Local copies of the bus inputs
  logic [7:0]  cmd;
  logic [7:0]  addr;
  logic [31:0] data;
  logic        addr_strobe;
  logic        data_strobe;

  assign cmd         = bus.Cmd;
  assign addr        = bus.Addr;
  assign data        = bus.Data;
  assign addr_strobe = bus.AddrStrobe;
  assign data_strobe = bus.DataStrobe;

  // Operand range checks: pin index and word index must address real pins.
  logic pin_ok;
  logic word_ok;

  assign pin_ok  = ({1'b0, addr[5:0]} < 7'(NPINS));
  assign word_ok = (addr < 8'(NWORDS));

  // Flattened per-pin state for the read mux and interrupt OR
  logic [NPINS-1:0] out_all;
  logic [NPINS-1:0] sync_all;
  logic [NPINS-1:0] flag_all;
  logic [NPINS-1:0] rmask_all;
  logic [NPINS-1:0] mode_hi_all;
  logic [NPINS-1:0] mode_lo_all;

  // Arming counter: edge detection only starts once the synchroniser has
  // flushed the reset value, so a pad already high at release is not an edge.
  logic [1:0] arm_q, arm_d;
  logic       armed;

  assign armed = (arm_q == 2'd3);

  // Arm counter next state: count up and saturate
  always_comb begin
    arm_d = armed ? arm_q : arm_q + 2'd1;
  end

  // Arm counter register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      arm_q <= 2'd0;
    end else begin
      arm_q <= arm_d;
    end
  end

  for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
    localparam int WI     = gi / 32;
    localparam int BI     = gi % 32;
    localparam bit PWM_OK = (gi < PWM_PINS);

    logic [1:0] mode_q, mode_d;
    logic       out_q, out_d;
    logic       rmask_q, rmask_d;
    logic       fmask_q, fmask_d;
    logic       flag_q, flag_d;
    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       pwm_pin;
    logic       pin_hit;
    logic       word_hit;
    logic       rise;
    logic       fall;
    logic       edge_set;

    if (gi < PWM_PINS) begin : g_pwm
      assign pwm_pin = PWM[gi];
    end else begin : g_nopwm
      assign pwm_pin = 1'b0;
    end

    assign pin_hit  = addr_strobe && (addr[5:0] == 6'(gi));
    assign word_hit = data_strobe && word_ok && (addr[0] == 1'(WI));
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;
    assign edge_set = armed && (mode_q == 2'b00) &&
                      ((rise && rmask_q) || (fall && fmask_q));

    // Per-pin next state: mode/out/mask writes, sticky flag with set-over-clear
    always_comb begin
      mode_d = mode_q;
      if (pin_hit) begin
        case (cmd)
          8'h08: mode_d = 2'b00;
          8'h09: mode_d = 2'b01;
          8'h0A: if (PWM_OK) mode_d = 2'b10;
          8'h0B: if (PWM_OK) mode_d = 2'b11;
          default: mode_d = mode_q;
        endcase
      end

      out_d = out_q;
      if (word_hit && (cmd == 8'h0D)) out_d = data[BI];
      if (pin_hit && (cmd == 8'h19))  out_d = 1'b1;
      if (pin_hit && (cmd == 8'h1A))  out_d = 1'b0;

      rmask_d = (word_hit && (cmd == 8'h15)) ? data[BI] : rmask_q;
      fmask_d = (word_hit && (cmd == 8'h16)) ? data[BI] : fmask_q;

      flag_d = flag_q;
      if (word_hit && (cmd == 8'h18) && data[BI]) flag_d = 1'b0;
      if (edge_set) flag_d = 1'b1;

      meta_d = Pin_In[gi];
      sync_d = meta_q;
      prev_d = sync_q;
    end

    // Per-pin state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        mode_q  <= 2'b00;
        out_q   <= 1'b0;
        rmask_q <= 1'b0;
        fmask_q <= 1'b0;
        flag_q  <= 1'b0;
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        prev_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        out_q   <= out_d;
        rmask_q <= rmask_d;
        fmask_q <= fmask_d;
        flag_q  <= flag_d;
        meta_q  <= meta_d;
        sync_q  <= sync_d;
        prev_q  <= prev_d;
      end
    end

    // Pad drive: PWM passes straight through with no register in the path
    assign Pin_Oe[gi]  = |mode_q;
    assign Pin_Out[gi] = (mode_q == 2'b01) ? out_q    :
                         (mode_q == 2'b11) ? pwm_pin  :
                         (mode_q == 2'b10) ? ~pwm_pin : 1'b0;

    assign out_all[gi]     = out_q;
    assign sync_all[gi]    = sync_q;
    assign flag_all[gi]    = flag_q;
    assign rmask_all[gi]   = rmask_q;
    assign mode_hi_all[gi] = mode_q[1];
    assign mode_lo_all[gi] = mode_q[0];
  end

  // Zero-extend to two full words so pad bits above NPINS read as 0
  logic [63:0] out_ext, sync_ext, flag_ext, rmask_ext, mode_hi_ext, mode_lo_ext;

  assign out_ext     = 64'(out_all);
  assign sync_ext    = 64'(sync_all);
  assign flag_ext    = 64'(flag_all);
  assign rmask_ext   = 64'(rmask_all);
  assign mode_hi_ext = 64'(mode_hi_all);
  assign mode_lo_ext = 64'(mode_lo_all);

  function automatic logic [31:0] pick_word(input logic [63:0] v, input logic sel);
    return sel ? v[63:32] : v[31:0];
  endfunction

  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        irq_q, irq_d;

  // Read decode: one-cycle valid pulse, data held until the next read
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (addr_strobe) begin
      case (cmd)
        8'h0C: begin
          rd_valid_d = 1'b1;
          rd_data_d  = pin_ok ? {30'b0, mode_hi_ext[addr[5:0]], mode_lo_ext[addr[5:0]]} : 32'b0;
        end
        8'h11: begin
          rd_valid_d = 1'b1;
          rd_data_d  = word_ok ? pick_word(out_ext, addr[0]) : 32'b0;
        end
        8'h13: begin
          rd_valid_d = 1'b1;
          rd_data_d  = word_ok ? pick_word(sync_ext, addr[0]) : 32'b0;
        end
        8'h17: begin
          rd_valid_d = 1'b1;
          rd_data_d  = word_ok ? pick_word(flag_ext, addr[0]) : 32'b0;
        end
        8'h1B: begin
          rd_valid_d = 1'b1;
          rd_data_d  = word_ok ? pick_word(rmask_ext, addr[0]) : 32'b0;
        end
        8'hFF: begin
          rd_valid_d = 1'b1;
          rd_data_d  = 32'h0002_0000 | 32'(NUM_PORTS);
        end
        default: begin
          rd_valid_d = 1'b0;
          rd_data_d  = rd_data_q;
        end
      endcase
    end
    irq_d = |flag_all;
  end

  // Read response and interrupt registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data_q  <= 32'b0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.Rd_Data  = rd_data_q;
  assign bus.Rd_Valid = rd_valid_q;
  assign Irq          = irq_q;

endmodule
